i2c_target_receiver: RTL and testbench
======================================

// Module: i2c_target_receiver
// PURPOSE
// - I2C write-only target: the far end of the transmitter FSM. Oversamples scl/sda with the system clock.
// - Detects START/STOP, shifts in the address byte, ACKs its own 7-bit address with R/W=0,
//   then receives data bytes, ACKing each one, and presents each byte on a one-cycle strobe.
// - Sits between the pad open-drain buffers and a register-file or FIFO consumer.
// PARAMETERS
// - OWN_ADDR     7'h3C  7-bit target address that is acknowledged.
// - SYNC_STAGES  2      flops in the scl/sda synchronizers (>=2).
// PORTS
// - clock       in   1  system clock, >= 8x the scl rate.
// - reset       in   1  synchronous, active-high.
// - scl_in      in   1  raw scl pad input.
// - sda_in      in   1  raw sda pad input.
// - sda_oe      out  1  1 = drive sda low (ACK); 0 = release.
// - rx_ready    in   1  consumer can accept a byte; sampled on the 8th data bit.
// - rx_data     out  8  last received byte, MSB first on the wire. Held until the next byte.
// - rx_valid    out  1  one-cycle strobe; rx_data is valid in the same cycle.
// - addr_match  out  1  high from the address ACK until STOP or repeated START.
// - busy        out  1  high from START until STOP.
// - stop_seen   out  1  one-cycle strobe on STOP detect.
// BEHAVIOUR
// - Reset: state=IDLE; all outputs 0, including rx_data=8'h00; bit counter 0.
// - Reset mid-transfer returns to IDLE and releases sda at once. It does not wait for STOP.
// - Sync: scl_s/sda_s come from SYNC_STAGES flops; previous-sample registers give edges.
//   Detection latency is SYNC_STAGES+1 clocks after the pad change.
// - START: sda_s falls while scl_s is high. STOP: sda_s rises while scl_s is high.
//   Both are checked before the data-bit logic in the same cycle.
// - Bit sampling: on each synchronized scl rising edge, shift sda_s into the shift register and
//   increment the 3-bit counter. The count wraps 7->0 on the 8th bit.
// - States:
//   - IDLE: wait for START -> ADDR.
//   - ADDR: 8 bits. On the 8th bit:
//     - [7:1]==OWN_ADDR and [0]==0 -> ADDR_ACK.
//     - otherwise -> IGNORE. A read request (R/W=1) is NACKed.
//   - ADDR_ACK: on the next scl falling edge set sda_oe=1 and addr_match=1.
//     On the following falling edge set sda_oe=0 -> DATA.
//   - DATA: 8 bits. On the 8th bit rx_data<=shift and rx_valid=1 for one cycle.
//     - rx_ready=1 -> DATA_ACK.
//     - rx_ready=0 -> rx_valid is still pulsed, then NACK -> IGNORE.
//   - DATA_ACK: same sda_oe timing as ADDR_ACK -> DATA.
//   - IGNORE: sda_oe=0; wait for STOP or START.
// - START in any state (repeated START) -> ADDR with counter=0, sda_oe=0, addr_match=0. busy stays 1.
// - STOP in any state -> IDLE with sda_oe=0, addr_match=0, busy=0, stop_seen=1.
//   A partial byte is discarded with no rx_valid.
// - sda_oe is never asserted while scl_s is high, except while holding an ACK across the ACK clock high.
// - busy=1 while state != IDLE.
// STRUCTURE
// - Shared header i2c_defs.vh holds:
//   - state encodings: one-hot, 6 states plus a default->IDLE entry;
//   - ACK=1'b0 and NACK=1'b1 constants;
//   - address width 7.
//   Shared with the transmitter FSM.
// - Sub-module i2c_line_sync covers synchronizers, scl rise/fall, start_det and stop_det.
// - The top holds the FSM, shift register and counter.
// TESTING
// - START, 0x78 (0x3C,W), ACK slot -> sda_oe high for exactly one scl period; addr_match=1.
//   Then byte 0xA5 -> rx_valid one pulse with rx_data=8'hA5, ACK driven.
// - Address 0x3D,W -> no sda_oe during the ACK slot; no rx_valid for the following byte 0x11; busy=1 until STOP.
// - Address 0x3C,R (0x79) -> NACK, state IGNORE; STOP -> stop_seen pulse, busy=0.
// - Bytes 0x01,0x02 with rx_ready=0 on the 2nd -> rx_valid for both; ACK after 0x01, NACK after 0x02.
// - Repeated START after 4 data bits, then 0x78, 0x5A -> partial byte dropped; rx_data=8'h5A; addr_match re-asserted.
// - reset asserted while sda_oe=1 mid-ACK -> sda_oe=0 and busy=0 the next cycle; STOP/START afterwards behave normally.

Source files
------------

// File: rtl/i2c_target_receiver_pkg.sv
// Shared I2C receive definitions: one-hot state encoding, ACK/NACK line levels, address width.
package i2c_target_receiver_pkg;

    localparam int   ADDR_W = 7;
    localparam logic ACK    = 1'b0;
    localparam logic NACK   = 1'b1;

    typedef enum logic [5:0] {
        ST_IDLE     = 6'b000001,
        ST_ADDR     = 6'b000010,
        ST_ADDR_ACK = 6'b000100,
        ST_DATA     = 6'b001000,
        ST_DATA_ACK = 6'b010000,
        ST_IGNORE   = 6'b100000
    } state_e;

    // Wire level the target answers with in the ninth clock.
    function automatic logic ack_resp(input logic accept);
        return accept ? ACK : NACK;
    endfunction

endpackage

// File: rtl/i2c_target_receiver_line_sync.sv
// scl/sda synchronizers plus scl edge and START/STOP condition detection.
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_s_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_det_o,
    output logic stop_det_o
);

    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic                   scl_prev_q, sda_prev_q;
    logic                   scl_s, sda_s;

    // Reset to the idle-bus level so leaving reset never fakes an edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    assign scl_s       = scl_sync_q[SYNC_STAGES-1];
    assign sda_s       = sda_sync_q[SYNC_STAGES-1];
    assign sda_s_o     = sda_s;
    assign scl_rise_o  = scl_s & ~scl_prev_q;
    assign scl_fall_o  = ~scl_s & scl_prev_q;
    assign start_det_o = scl_s & sda_prev_q & ~sda_s;
    assign stop_det_o  = scl_s & ~sda_prev_q & sda_s;

endmodule

// File: rtl/i2c_target_receiver.sv
// Write-only I2C target: acknowledges OWN_ADDR with R/W=0 and strobes out each received byte.
module i2c_target_receiver
    import i2c_target_receiver_pkg::*;
#(
    parameter logic [ADDR_W-1:0] OWN_ADDR    = 7'h3C,
    parameter int                SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       addr_match,
    output logic       busy,
    output logic       stop_seen
);

    logic       sda_s, scl_rise, scl_fall, start_det, stop_det;
    state_e     state_q;
    logic [6:0] shift_q;
    logic [7:0] shift_d;
    logic [2:0] cnt_q;
    logic       sda_oe_q, rx_valid_q, addr_match_q, stop_seen_q;
    logic [7:0] rx_data_q;
    logic       addr_ok;

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clock      (clock),
        .reset      (reset),
        .scl_i      (scl_in),
        .sda_i      (sda_in),
        .sda_s_o    (sda_s),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall),
        .start_det_o(start_det),
        .stop_det_o (stop_det)
    );

    assign shift_d = {shift_q, sda_s};
    assign addr_ok = (shift_d[7:1] == OWN_ADDR) && (shift_d[0] == 1'b0);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            shift_q      <= '0;
            cnt_q        <= '0;
            sda_oe_q     <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            addr_match_q <= 1'b0;
            stop_seen_q  <= 1'b0;
        end else begin
            rx_valid_q  <= 1'b0;
            stop_seen_q <= 1'b0;
            if (stop_det) begin
                state_q      <= ST_IDLE;
                cnt_q        <= '0;
                sda_oe_q     <= 1'b0;
                addr_match_q <= 1'b0;
                stop_seen_q  <= 1'b1;
            end else if (start_det) begin
                state_q      <= ST_ADDR;
                cnt_q        <= '0;
                sda_oe_q     <= 1'b0;
                addr_match_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: ;
                    ST_ADDR: if (scl_rise) begin
                        shift_q <= shift_d[6:0];
                        cnt_q   <= cnt_q + 3'd1;
                        if (cnt_q == 3'd7)
                            state_q <= (ack_resp(addr_ok) == ACK) ? ST_ADDR_ACK : ST_IGNORE;
                    end
                    // First fall opens the ACK slot, second fall closes it; sda_oe_q marks the phase.
                    ST_ADDR_ACK, ST_DATA_ACK: if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_q     <= 1'b1;
                            addr_match_q <= 1'b1;
                        end else begin
                            sda_oe_q <= 1'b0;
                            state_q  <= ST_DATA;
                        end
                    end
                    ST_DATA: if (scl_rise) begin
                        shift_q <= shift_d[6:0];
                        cnt_q   <= cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            rx_data_q  <= shift_d;
                            rx_valid_q <= 1'b1;
                            state_q    <= (ack_resp(rx_ready) == ACK) ? ST_DATA_ACK : ST_IGNORE;
                        end
                    end
                    ST_IGNORE: sda_oe_q <= 1'b0;
                    default: begin
                        state_q  <= ST_IDLE;
                        sda_oe_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sda_oe     = sda_oe_q;
    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign addr_match = addr_match_q;
    assign busy       = (state_q != ST_IDLE);
    assign stop_seen  = stop_seen_q;

endmodule

// File: tb/tb_i2c_target_receiver.sv
// Drives I2C write transactions as a bus master and checks ACKs, received bytes and status against a transaction-level model.
module tb_i2c_target_receiver;

    localparam int Q = 6;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       rx_ready = 1'b1;
    logic       sda_in;
    logic       sda_oe, rx_valid, addr_match, busy, stop_seen;
    logic [7:0] rx_data;

    int errors = 0;
    int checks = 0;
    logic [7:0] rx_q[$];
    int stop_cnt = 0;

    // Open-drain bus: the target can only pull sda low.
    assign sda_in = sda_m & ~sda_oe;

    i2c_target_receiver dut (
        .clock     (clock),
        .reset     (reset),
        .scl_in    (scl_m),
        .sda_in    (sda_in),
        .sda_oe    (sda_oe),
        .rx_ready  (rx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .addr_match(addr_match),
        .busy      (busy),
        .stop_seen (stop_seen)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (rx_valid) rx_q.push_back(rx_data);
        if (stop_seen) stop_cnt <= stop_cnt + 1;
    end

    typedef struct {
        logic [7:0]      addr;
        int              n;
        logic [3:0][7:0] d;
        logic [3:0]      rdy;
        logic [4:0]      exp_ack;
        int              exp_rx;
        logic [7:0]      exp_last;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wt(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wt(Q);
        scl_m = 1'b1; wt(Q);
        sda_m = 1'b0; wt(Q);
        scl_m = 1'b0; wt(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wt(Q);
        scl_m = 1'b1; wt(Q);
        sda_m = 1'b1; wt(Q);
    endtask

    // One scl clock; oe_hi is sda_oe sampled in the middle of the high phase.
    task automatic send_bit(input logic b, output logic oe_hi);
        sda_m = b;    wt(Q);
        scl_m = 1'b1; wt(Q);
        oe_hi = sda_oe; wt(Q);
        scl_m = 1'b0; wt(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack, inout int bad);
        logic oe;
        for (int i = 7; i >= 0; i--) begin
            send_bit(b[i], oe);
            if (oe) bad++;
        end
        send_bit(1'b1, ack);
        chk("ack_release", 32'(sda_oe), 32'd0);
    endtask

    // Spec-level expectation: only 0x3C with W is acked; bytes flow until the first refused one.
    function automatic void model(input logic [7:0] addr, input int n, input logic [3:0] rdy,
                                  output logic [4:0] acks, output int nrx);
        acks = '0;
        nrx  = 0;
        if (addr != 8'h78) return;
        acks[0] = 1'b1;
        for (int i = 0; i < n; i++) begin
            nrx++;
            if (!rdy[i]) break;
            acks[i+1] = 1'b1;
        end
    endfunction

    task automatic xfer(input string tag, input logic [7:0] addr, input int n,
                        input logic [3:0][7:0] d, input logic [3:0] rdy,
                        output logic [4:0] acks, output int got_rx);
        int base = rx_q.size();
        int bad = 0;
        int sbase;
        int nrx;
        logic a;
        logic [4:0] macks;
        acks = '0;
        model(addr, n, rdy, macks, nrx);
        i2c_start();
        send_byte(addr, a, bad);
        acks[0] = a;
        for (int i = 0; i < n; i++) begin
            rx_ready = rdy[i];
            send_byte(d[i], a, bad);
            acks[i+1] = a;
        end
        rx_ready = 1'b1;
        got_rx = rx_q.size() - base;
        chk({tag, "/acks"}, 32'(acks), 32'(macks));
        chk({tag, "/rx_count"}, 32'(got_rx), 32'(nrx));
        for (int i = 0; i < nrx && i < got_rx; i++)
            chk({tag, "/rx_byte"}, 32'(rx_q[base+i]), 32'(d[i]));
        chk({tag, "/addr_match"}, 32'(addr_match), 32'(addr == 8'h78));
        chk({tag, "/oe_in_data"}, 32'(bad), 32'd0);
        chk({tag, "/busy_before_stop"}, 32'(busy), 32'd1);
        sbase = stop_cnt;
        i2c_stop();
        wt(Q);
        chk({tag, "/busy_after_stop"}, 32'(busy), 32'd0);
        chk({tag, "/stop_seen"}, 32'(stop_cnt - sbase), 32'd1);
    endtask

    initial begin
        vec_t       vt[5];
        logic [4:0] acks;
        int         got;
        int         bad;
        int         base;
        int         sbase;
        logic       a;
        logic       oe;
        logic [7:0] raddr;
        int         rn;
        logic [3:0][7:0] rd;
        logic [3:0] rrdy;

        vt[0] = '{8'h78, 1, {8'h00, 8'h00, 8'h00, 8'hA5}, 4'b0001, 5'b00011, 1, 8'hA5};
        vt[1] = '{8'h7A, 1, {8'h00, 8'h00, 8'h00, 8'h11}, 4'b0001, 5'b00000, 0, 8'hA5};
        vt[2] = '{8'h79, 1, {8'h00, 8'h00, 8'h00, 8'h33}, 4'b0001, 5'b00000, 0, 8'hA5};
        vt[3] = '{8'h78, 2, {8'h00, 8'h00, 8'h02, 8'h01}, 4'b0001, 5'b00011, 2, 8'h02};
        vt[4] = '{8'h78, 3, {8'h00, 8'h30, 8'h20, 8'h10}, 4'b0111, 5'b01111, 3, 8'h30};

        wt(4);
        chk("reset/sda_oe", 32'(sda_oe), 32'd0);
        chk("reset/rx_data", 32'(rx_data), 32'd0);
        chk("reset/rx_valid", 32'(rx_valid), 32'd0);
        chk("reset/addr_match", 32'(addr_match), 32'd0);
        chk("reset/busy", 32'(busy), 32'd0);
        chk("reset/stop_seen", 32'(stop_seen), 32'd0);
        reset = 1'b0;
        wt(4);

        for (int k = 0; k < 5; k++) begin
            xfer($sformatf("vec%0d", k), vt[k].addr, vt[k].n, vt[k].d, vt[k].rdy, acks, got);
            chk($sformatf("vec%0d/tbl_acks", k), 32'(acks), 32'(vt[k].exp_ack));
            chk($sformatf("vec%0d/tbl_rx", k), 32'(got), 32'(vt[k].exp_rx));
            chk($sformatf("vec%0d/rx_data_held", k), 32'(rx_data), 32'(vt[k].exp_last));
        end

        // Repeated START after a partial byte drops those bits and clears addr_match.
        base = rx_q.size();
        bad = 0;
        i2c_start();
        send_byte(8'h78, a, bad);
        chk("rs/first_ack", 32'(a), 32'd1);
        send_bit(1'b1, oe); send_bit(1'b0, oe); send_bit(1'b1, oe); send_bit(1'b1, oe);
        i2c_start();
        chk("rs/addr_match_cleared", 32'(addr_match), 32'd0);
        chk("rs/busy_held", 32'(busy), 32'd1);
        send_byte(8'h78, a, bad);
        chk("rs/second_ack", 32'(a), 32'd1);
        send_byte(8'h5A, a, bad);
        chk("rs/data_ack", 32'(a), 32'd1);
        chk("rs/rx_count", 32'(rx_q.size() - base), 32'd1);
        chk("rs/rx_data", 32'(rx_data), 32'h5A);
        chk("rs/addr_match", 32'(addr_match), 32'd1);
        i2c_stop();
        wt(Q);
        chk("rs/busy_after_stop", 32'(busy), 32'd0);

        // Reset while the target is holding the address ACK.
        i2c_start();
        for (int i = 7; i >= 0; i--) send_bit(raddr_bit(i), oe);
        sda_m = 1'b1; wt(Q);
        scl_m = 1'b1; wt(Q);
        chk("rst_ack/oe_before", 32'(sda_oe), 32'd1);
        reset = 1'b1; wt(1);
        chk("rst_ack/sda_oe", 32'(sda_oe), 32'd0);
        chk("rst_ack/busy", 32'(busy), 32'd0);
        reset = 1'b0; wt(Q);
        scl_m = 1'b0; wt(Q);
        sbase = stop_cnt;
        i2c_stop();
        wt(Q);
        chk("rst_ack/stop_seen", 32'(stop_cnt - sbase), 32'd1);
        xfer("post_reset", 8'h78, 1, {8'h00, 8'h00, 8'h00, 8'hC3}, 4'b0001, acks, got);
        chk("post_reset/rx_data", 32'(rx_data), 32'hC3);

        for (int k = 0; k < 12; k++) begin
            case ($urandom_range(0, 3))
                0, 1: raddr = 8'h78;
                2:    raddr = 8'h79;
                default: raddr = 8'($urandom_range(0, 255));
            endcase
            rn = $urandom_range(1, 4);
            for (int i = 0; i < 4; i++) begin
                rd[i]   = 8'($urandom_range(0, 255));
                rrdy[i] = ($urandom_range(0, 3) != 0);
            end
            xfer($sformatf("rnd%0d", k), raddr, rn, rd, rrdy, acks, got);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    function automatic logic raddr_bit(input int i);
        logic [7:0] v = 8'h78;
        return v[i];
    endfunction

endmodule
